// File: rtl/picomem_wbuf.sv
// picomem_wbuf: posted-write buffer in front of the PSRAM picomem controller.
// Latency: writes ack 1 cycle after acceptance; reads ack 1 cycle after mem_ready (forwarded reads 2 cycles after valid).
// Backpressure: a full buffer stalls writes, reads stall until drained and mem_init_ready; downstream paced by mem_ready.
// Optional feature: define PICOMEM_WBUF_FWD_EN to forward full-word buffered writes to reads.
module picomem_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   sys_resetn,
  input  logic                   valid,
  output logic                   ready,
  input  logic [31:0]            addr,
  input  logic [3:0]             wstrb,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [31:0]            mem_addr,
  output logic [3:0]             mem_wstrb,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_init_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {U_IDLE, U_RDWAIT, U_RESP} u_state_t;
  typedef enum logic [1:0] {D_IDLE, D_WR, D_RD} d_state_t;

  u_state_t r_u_state;
  u_state_t w_u_next;
  d_state_t r_d_state;
  d_state_t w_d_next;

  // Buffer storage: one entry per posted write.
  logic [31:0]   r_buf_addr [DEPTH];
  logic [3:0]    r_buf_strb [DEPTH];
  logic [31:0]   r_buf_dat  [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic [31:0]   r_rdata;
  logic [31:0]   r_mem_addr;
  logic [3:0]    r_mem_wstrb;
  logic [31:0]   r_mem_wdata;

  logic          w_is_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_rd_pend;
  logic          w_rd_done;
  logic          w_fwd_hit;
  logic          w_rd_accept;

  assign w_is_wr     = |wstrb;
  assign w_push      = (r_u_state == U_IDLE) && valid && w_is_wr && (r_level != FULL);
  assign w_rd_accept = (r_u_state == U_IDLE) && valid && !w_is_wr;
  // mem_ready only counts while a downstream request is outstanding.
  assign w_pop       = (r_d_state == D_WR) && mem_ready;
  assign w_rd_done   = (r_d_state == D_RD) && mem_ready;
  assign w_rd_pend   = (r_u_state == U_RDWAIT) && !w_fwd_hit;

`ifdef PICOMEM_WBUF_FWD_EN
  logic          r_fwd_hit;
  logic [31:0]   r_fwd_dat;
  logic          w_m_vld;
  logic [3:0]    w_m_strb;
  logic [31:0]   w_m_dat;
  logic [PW-1:0] w_idx;

  // Scan oldest to newest so the last match left standing is the newest one.
  always_comb begin
    w_m_vld  = 1'b0;
    w_m_strb = 4'h0;
    w_m_dat  = 32'h0;
    w_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if ((LW'(i) < r_level) && (r_buf_addr[w_idx][31:2] == addr[31:2])) begin
        w_m_vld  = 1'b1;
        w_m_strb = r_buf_strb[w_idx];
        w_m_dat  = r_buf_dat[w_idx];
      end
    end
  end

  // Capture the lookup at read acceptance; only a full-word newest match forwards.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_fwd_hit <= 1'b0;
      r_fwd_dat <= 32'h0;
    end else if (w_rd_accept) begin
      r_fwd_hit <= w_m_vld && (w_m_strb == 4'hF);
      r_fwd_dat <= w_m_dat;
    end else if (r_u_state == U_RESP) begin
      r_fwd_hit <= 1'b0;
    end
  end

  assign w_fwd_hit = r_fwd_hit;
`else
  assign w_fwd_hit = 1'b0;
`endif

  // Upstream FSM state register.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) r_u_state <= U_IDLE;
    else             r_u_state <= w_u_next;
  end

  // Upstream next state: writes ack straight away, reads wait for data.
  always_comb begin
    w_u_next = r_u_state;
    case (r_u_state)
      U_IDLE: begin
        if (w_push)           w_u_next = U_RESP;
        else if (w_rd_accept) w_u_next = U_RDWAIT;
      end
      U_RDWAIT: begin
        if (w_fwd_hit || w_rd_done) w_u_next = U_RESP;
      end
      U_RESP:  w_u_next = U_IDLE;
      default: w_u_next = U_IDLE;
    endcase
  end

  // Upstream outputs: ready is high for exactly the one U_RESP cycle.
  always_comb begin
    ready = (r_u_state == U_RESP);
  end

  // Downstream FSM state register.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) r_d_state <= D_IDLE;
    else             r_d_state <= w_d_next;
  end

  // Downstream next state: writes drain first, a read goes only once empty.
  always_comb begin
    w_d_next = r_d_state;
    case (r_d_state)
      D_IDLE: begin
        if (mem_init_ready) begin
          if (r_level != '0)  w_d_next = D_WR;
          else if (w_rd_pend) w_d_next = D_RD;
        end
      end
      D_WR:    if (mem_ready) w_d_next = D_IDLE;
      D_RD:    if (mem_ready) w_d_next = D_IDLE;
      default: w_d_next = D_IDLE;
    endcase
  end

  // Downstream outputs: mem_valid follows the state so reset drops it at once.
  always_comb begin
    mem_valid = (r_d_state != D_IDLE);
  end

  // Launch registers: loaded only when leaving D_IDLE, so they hold until mem_ready.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_mem_addr  <= 32'h0;
      r_mem_wstrb <= 4'h0;
      r_mem_wdata <= 32'h0;
    end else if (r_d_state == D_IDLE && w_d_next == D_WR) begin
      r_mem_addr  <= r_buf_addr[r_rptr];
      r_mem_wstrb <= r_buf_strb[r_rptr];
      r_mem_wdata <= r_buf_dat[r_rptr];
    end else if (r_d_state == D_IDLE && w_d_next == D_RD) begin
      r_mem_addr  <= addr;
      r_mem_wstrb <= 4'h0;
      r_mem_wdata <= 32'h0;
    end
  end

  // Entry payload write; contents need no reset since level gates every use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_addr[r_wptr] <= addr;
      r_buf_strb[r_wptr] <= wstrb;
      r_buf_dat[r_wptr]  <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Read data is captured on completion and held until the next read returns.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_rdata <= 32'h0;
    end else if (r_u_state == U_RDWAIT) begin
      if (w_rd_done) r_rdata <= mem_rdata;
`ifdef PICOMEM_WBUF_FWD_EN
      else if (r_fwd_hit) r_rdata <= r_fwd_dat;
`endif
    end
  end

  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;
  assign level     = r_level;

endmodule

// File: tb/tb_picomem_wbuf.sv
`timescale 1ns/1ps
// Bench for picomem_wbuf: directed scenarios plus a random mix, checked against
// a program-order memory model and an expected downstream-write queue.
module tb_picomem_wbuf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        sys_resetn;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_init_ready;
  logic [$clog2(DEPTH):0] level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  picomem_wbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .sys_resetn(sys_resetn), .valid(valid), .ready(ready),
    .addr(addr), .wstrb(wstrb), .wdata(wdata), .rdata(rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_init_ready(mem_init_ready), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] ref_mem [bit [29:0]];
  logic [31:0] dev_mem [bit [29:0]];
  logic [31:0] rd_addr_exp = 32'h0;

  logic hold = 1'b0;
  logic spur = 1'b0;
  logic arm_pop = 1'b0;
  int   first_pop_cyc = 0;
  int   req_cnt = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (dev_mem.exists(a[31:2])) return dev_mem[a[31:2]];
    return init_word(a);
  endfunction

  // Downstream PSRAM responder: random latency, checks each request against the model.
  initial begin : responder
    int   rlat;
    int   cnt;
    logic busy;
    logic prev;
    logic spur_prev;
    logic pop_taken;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    wr_t  e;
    rlat = 1; cnt = 0; busy = 0; prev = 0; spur_prev = 0; pop_taken = 0;
    a0 = 0; d0 = 0; s0 = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!arm_pop) pop_taken = 0;
      if (mem_valid && !prev) begin
        req_cnt++;
        a0 = mem_addr; s0 = mem_wstrb; d0 = mem_wdata;
        busy = 1;
      end
      prev = mem_valid;
      if (!mem_valid) begin busy = 0; cnt = 0; end
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (spur && !spur_prev && !mem_valid) begin
        mem_ready = 1'b1;
      end else if (busy && !hold) begin
        if (cnt >= rlat) begin
          check("stable_addr", mem_addr, a0);
          check("stable_wstrb", {28'h0, mem_wstrb}, {28'h0, s0});
          check("stable_wdata", mem_wdata, d0);
          if (mem_wstrb != 4'h0) begin
            wr_cnt++;
            if (arm_pop && !pop_taken) begin first_pop_cyc = cyc; pop_taken = 1; end
            check("wr_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("wr_addr", mem_addr, e.a);
              check("wr_wstrb", {28'h0, mem_wstrb}, {28'h0, e.s});
              check("wr_wdata", mem_wdata, e.d);
            end
            dev_mem[mem_addr[31:2]] = merge(dev_rd(mem_addr), mem_wstrb, mem_wdata);
          end else begin
            rd_cnt++;
            check("rd_after_drain", exp_q.size(), 0);
            check("rd_addr", mem_addr, rd_addr_exp);
            mem_rdata = dev_rd(mem_addr);
          end
          mem_ready = 1'b1;
          busy = 0; cnt = 0;
          rlat = $urandom_range(0, 3);
        end else begin
          cnt++;
        end
      end
      spur_prev = spur;
    end
  end

  task automatic drive_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    exp_q.push_back({a, s, d});
    ref_mem[a[31:2]] = merge(ref_rd(a), s, d);
    addr = a; wstrb = s; wdata = d; valid = 1'b1;
  endtask

  task automatic wait_ready(input string tag, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ready && lat < 300);
    if (!ready) check(tag, {31'h0, ready}, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, output int lat);
    drive_write(a, s, d);
    wait_ready("wr_timeout", lat);
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input string tag, output int lat);
    rd_addr_exp = a;
    addr = a; wstrb = 4'h0; wdata = $urandom; valid = 1'b1;
    wait_ready("rd_timeout", lat);
    check(tag, rdata, ref_rd(a));
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((level != 0 || mem_valid) && n < 300) begin @(negedge clk); n++; end
    if (level != 0 || mem_valid) check(tag, {29'h0, level}, 0);
    @(negedge clk);
  endtask

  initial begin : main
    int lat;
    int n;
    int r0;
    logic seen;
    logic mv;
    logic [31:0] a;
    valid = 0; addr = 0; wstrb = 0; wdata = 0;
    mem_init_ready = 0; sys_resetn = 0;
    repeat (3) @(negedge clk);

    check("rst_ready", {31'h0, ready}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_valid", {31'h0, mem_valid}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", {28'h0, mem_wstrb}, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_level", {29'h0, level}, 0);
    sys_resetn = 1;
    @(negedge clk);
    mem_init_ready = 1;

    // Single posted write goes downstream once, unmodified.
    n = req_cnt;
    do_write(32'h100, 4'hF, 32'hDEADBEEF, lat);
    check("w1_latency", lat, 1);
    wait_idle("w1_drain");
    check("w1_requests", req_cnt - n, 1);
    check("w1_level", {29'h0, level}, 0);

    // Fill with mem_ready held off, then a fifth write must wait for the first pop.
    hold = 1;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(32'h1000 + 32'(4 * i), 4'hF, $urandom, lat);
      check("fill_latency", lat, 1);
    end
    check("fill_level", {29'h0, level}, DEPTH);
    drive_write(32'h1010, 4'hF, 32'h5555_AAAA);
    seen = 0;
    repeat (6) begin @(negedge clk); if (ready) seen = 1; end
    check("full_stall_ready", {31'h0, seen}, 0);
    check("full_stall_level", {29'h0, level}, DEPTH);
    arm_pop = 1;
    hold = 0;
    wait_ready("full_timeout", lat);
    check("full_ack_after_pop", cyc - first_pop_cyc, 2);
    valid = 0;
    arm_pop = 0;
    @(negedge clk);
    wait_idle("full_drain");

    // Random mix of writes and reads over a few words.
    for (int k = 0; k < 60; k++) begin
      a = 32'h2000 + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) do_read(a, "rand_rdata", lat);
      else do_write(a + 32'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), $urandom, lat);
    end
    wait_idle("rand_drain");

    // Write then immediate read of the same word.
    r0 = rd_cnt;
`ifdef PICOMEM_WBUF_FWD_EN
    hold = 1;
    do_write(32'h200, 4'hF, 32'h11223344, lat);
    do_read(32'h200, "raw_rdata", lat);
    check("fwd_latency", lat, 2);
    check("fwd_no_mem_read", rd_cnt - r0, 0);
    hold = 0;
`else
    do_write(32'h200, 4'hF, 32'h11223344, lat);
    do_read(32'h200, "raw_rdata", lat);
    check("raw_mem_read", rd_cnt - r0, 1);
`endif
    check("raw_value", rdata, 32'h11223344);
    wait_idle("raw_drain");
    r0 = rd_cnt;
    do_write(32'h300, 4'h3, 32'hAABBCCDD, lat);
    do_read(32'h300, "partial_rdata", lat);
    check("partial_mem_read", rd_cnt - r0, 1);
    wait_idle("partial_drain");

    // Before init: writes ack, read stalls, nothing goes downstream.
    mem_init_ready = 0;
    n = req_cnt;
    for (int i = 0; i < 3; i++) begin
      do_write(32'h410 + 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i), lat);
      check("preinit_latency", lat, 1);
    end
    check("preinit_level", {29'h0, level}, 3);
    spur = 1;
    repeat (3) @(negedge clk);
    spur = 0;
    check("spurious_ready_level", {29'h0, level}, 3);
    rd_addr_exp = 32'h400;
    addr = 32'h400; wstrb = 0; valid = 1;
    seen = 0; mv = 0;
    repeat (8) begin @(negedge clk); if (ready) seen = 1; if (mem_valid) mv = 1; end
    check("preinit_rd_stall", {31'h0, seen}, 0);
    check("preinit_no_mem_valid", {31'h0, mv}, 0);
    check("preinit_level_hold", {29'h0, level}, 3);
    mem_init_ready = 1;
    wait_ready("init_rd_timeout", lat);
    check("init_rdata", rdata, ref_rd(32'h400));
    valid = 0;
    @(negedge clk);
    check("init_requests", req_cnt - n, 4);
    wait_idle("init_drain");

    // Reset in the middle of a held downstream write.
    hold = 1;
    do_write(32'h600, 4'hF, 32'h6666_0000, lat);
    do_write(32'h604, 4'hF, 32'h6666_0004, lat);
    n = 0;
    while (!mem_valid && n < 50) begin @(negedge clk); n++; end
    check("mid_mem_valid", {31'h0, mem_valid}, 1);
    check("mid_level", {29'h0, level}, 2);
    #2 sys_resetn = 0;
    #1;
    check("async_mem_valid", {31'h0, mem_valid}, 0);
    check("async_level", {29'h0, level}, 0);
    check("async_mem_addr", mem_addr, 0);
    exp_q.delete();
    @(negedge clk);
    sys_resetn = 1;
    hold = 0;
    n = req_cnt;
    repeat (20) @(negedge clk);
    check("no_stale_request", req_cnt - n, 0);
    check("post_rst_level", {29'h0, level}, 0);
    check("post_rst_rdata", rdata, 0);
    do_write(32'h700, 4'hF, 32'h7777_7777, lat);
    do_read(32'h700, "post_rst_rd", lat);
    wait_idle("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/picomem_wbuf.md
PICOMEM_WBUF -- requirements
Module: picomem_wbuf

Interface
REQ-001 Parameter DEPTH, default 4, meaning: posted-write buffer entries; power of two, range 2..16.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 sys_resetn  input  1  reset, asynchronous and active-low.
REQ-004 valid  input  1  upstream request; held until ready.
REQ-005 ready  output  1  upstream completion; one-cycle pulse.
REQ-006 addr  input  32  upstream byte address.
REQ-007 wstrb  input  4  byte enables; 4'h0 means read.
REQ-008 wdata  input  32  upstream write data.
REQ-009 rdata  output  32  read data; valid with ready and held until the next read completes.
REQ-010 mem_valid  output  1  downstream request to the PSRAM picomem controller.
REQ-011 mem_ready  input  1  downstream one-cycle completion pulse.
REQ-012 mem_addr  output  32  downstream address.
REQ-013 mem_wstrb  output  4  downstream byte enables.
REQ-014 mem_wdata  output  32  downstream write data.
REQ-015 mem_rdata  input  32  downstream read data; sampled on mem_ready.
REQ-016 mem_init_ready  input  1  downstream initialisation complete.
REQ-017 level  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-018 Each write SHALL be posted: when valid=1, wstrb!=0 and level<DEPTH, the block SHALL push {addr,wstrb,wdata}, and ready SHALL pulse on the following cycle.
REQ-019 When the buffer is full, the block SHALL stall the write with ready=0 and SHALL accept it in the cycle after a pop frees an entry.
REQ-020 The block SHALL NOT accept a new upstream request in the cycle its ready pulse is high.
REQ-021 A read SHALL wait until level=0 and no downstream write is in flight, then issue one downstream read with mem_wstrb=0. It SHALL register mem_rdata into rdata on mem_ready and pulse ready on the next cycle.
REQ-022 The upstream FSM SHALL have states U_IDLE, U_RDWAIT (drain then read issued) and U_RESP (ready pulse), and SHALL return from U_RESP to U_IDLE.
REQ-023 The downstream FSM SHALL have states D_IDLE, D_WR and D_RD.
REQ-024 In D_IDLE with mem_init_ready=1, the downstream FSM SHALL select D_WR if level>0, else D_RD if a read is pending.
REQ-025 In D_WR and D_RD, mem_valid SHALL be 1 and mem_addr/mem_wstrb/mem_wdata SHALL be stable until mem_ready.
REQ-026 On mem_ready the downstream FSM SHALL return to D_IDLE with mem_valid=0; D_WR SHALL also pop the head entry.
REQ-027 mem_valid SHALL be low for at least one cycle between consecutive downstream requests.
REQ-028 Writes SHALL reach downstream in strict FIFO order, unmodified and never merged.
REQ-029 A simultaneous push and pop SHALL leave level unchanged; the read/write pointers SHALL wrap modulo DEPTH.
REQ-030 Before mem_init_ready=1, the block SHALL accept up to DEPTH writes, SHALL issue no downstream request, and SHALL stall reads.
REQ-031 A mem_ready that arrives while mem_valid=0 SHALL be ignored.

Reset
REQ-032 Reset SHALL force ready=0, rdata=0, mem_valid=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, level=0, both pointers=0, U_IDLE and D_IDLE.
REQ-033 Reset asserted mid-operation SHALL discard all buffered writes and any pending read, and mem_valid SHALL fall without waiting for clk.

Configuration
REQ-034 With macro PICOMEM_WBUF_FWD_EN defined, a read SHALL first search the buffer for the newest entry whose addr[31:2] matches.
REQ-035 With PICOMEM_WBUF_FWD_EN, when that newest matching entry has wstrb=4'hF, rdata SHALL take that entry's wdata, ready SHALL pulse 2 cycles after valid, and no downstream read SHALL be issued.
REQ-036 With PICOMEM_WBUF_FWD_EN, when that newest matching entry has a partial wstrb, the read SHALL follow REQ-021.
REQ-037 With PICOMEM_WBUF_FWD_EN, when no entry matches, the read SHALL follow REQ-021.
REQ-038 Without the macro, every read SHALL follow REQ-021 and no comparator logic SHALL be generated.

Verification
REQ-039 Scenario: mem_init_ready=1, write 0x100 <- 0xDEADBEEF with wstrb=F -> ready 1 cycle after valid; one mem_valid request carrying the same addr, wstrb and wdata; level returns to 0 after mem_ready.
REQ-040 Scenario: DEPTH=4, mem_ready held off, 5 writes -> 4 accepted, level=4; 5th ready occurs only in the cycle after the first pop.
REQ-041 Scenario: write 0x200 <- 0x11223344 then immediately read 0x200, with fwd off -> read issued downstream only after the write's mem_ready; rdata=mem_rdata.
REQ-042 Scenario: same sequence with PICOMEM_WBUF_FWD_EN -> rdata=0x11223344 in 2 cycles, no downstream read; with write wstrb=4'h3 instead -> downstream read after drain.
REQ-043 Scenario: mem_init_ready=0, 3 writes then 1 read -> writes acked, level=3, read stalls, mem_valid=0; raise mem_init_ready -> 3 writes drain in order, then read.
REQ-044 Scenario: assert sys_resetn=0 while in D_WR with level=2 -> mem_valid=0 asynchronously, level=0; after release no stale downstream request occurs.
